// File: rtl/rom_playback_sched_pkg.sv
// Shared constants and state encoding for the waveform ROM
// playback scheduler.
package rom_pkg;

    localparam int NROM = 4;
    localparam int SW   = 8;
    localparam int AW   = 8;

    localparam int DIV_DEF  = 11;
    localparam int LEN0_DEF = 132;
    localparam int LEN1_DEF = 121;
    localparam int LEN2_DEF = 88;
    localparam int LEN3_DEF = 55;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    typedef logic [SW-1:0] sample_t;
    typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/rom_playback_sched_tick_gen.sv
// Sample-rate prescaler: counts 0..DIV-1 and flags the
// last count as the sample tick.
module sample_tick_gen
    import rom_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/rom_playback_sched.sv
// Round-robin scheduler for four waveform ROMs sharing one
// address bus, emitting one sample every DIV cycles.
module rom_playback_sched
    import rom_pkg::*;
#(
    parameter int DIV  = DIV_DEF,
    parameter int LEN0 = LEN0_DEF,
    parameter int LEN1 = LEN1_DEF,
    parameter int LEN2 = LEN2_DEF,
    parameter int LEN3 = LEN3_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [3:0]    en,
    input  logic [SW-1:0] rom0_data,
    input  logic [SW-1:0] rom1_data,
    input  logic [SW-1:0] rom2_data,
    input  logic [SW-1:0] rom3_data,
    output logic [AW-1:0] addr,
    output logic [1:0]    sel,
    output logic [SW-1:0] sample,
    output logic          sample_valid,
    output logic          seg_done,
    output logic          busy
);

    state_t  state;
    logic    tick;
    logic    clear;
    sample_t rom_mux;
    addr_t   last_addr;
    logic    at_last;
    logic [2:0] nxt;
    logic [2:0] first;

    // Search s+1, s+2, s+3, s; bit 2 flags a hit.
    function automatic logic [2:0] rr_next(
        input logic [3:0] e,
        input logic [1:0] s
    );
        logic [2:0] r;
        logic [1:0] j;
        r = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            j = s + 2'(i);
            if (!r[2] && e[j]) begin
                r = {1'b1, j};
            end
        end
        return r;
    endfunction

    assign clear = (state != PLAY) || !run;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        rom_mux = '0;
        unique case (sel)
            2'd0: rom_mux = rom0_data;
            2'd1: rom_mux = rom1_data;
            2'd2: rom_mux = rom2_data;
            2'd3: rom_mux = rom3_data;
        endcase
    end

    always_comb begin
        last_addr = '0;
        unique case (sel)
            2'd0: last_addr = AW'(LEN0 - 1);
            2'd1: last_addr = AW'(LEN1 - 1);
            2'd2: last_addr = AW'(LEN2 - 1);
            2'd3: last_addr = AW'(LEN3 - 1);
        endcase
    end

    assign at_last = (addr == last_addr);
    assign nxt     = rr_next(en, sel);
    assign first   = rr_next(en, 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            sel          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            seg_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    addr         <= '0;
                    sel          <= '0;
                    sample       <= '0;
                    sample_valid <= 1'b0;
                    seg_done     <= 1'b0;
                    busy         <= 1'b0;
                    if (run && first[2]) begin
                        state <= PLAY;
                        busy  <= 1'b1;
                        sel   <= first[1:0];
                    end
                end
                PLAY: begin
                    if (!run) begin
                        state        <= IDLE;
                        addr         <= '0;
                        sel          <= '0;
                        sample       <= '0;
                        sample_valid <= 1'b0;
                        seg_done     <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        sample_valid <= tick;
                        seg_done     <= 1'b0;
                        if (tick) begin
                            sample <= rom_mux;
                            if (at_last) begin
                                seg_done <= 1'b1;
                                addr     <= '0;
                                if (nxt[2]) begin
                                    sel <= nxt[1:0];
                                end else begin
                                    // en emptied: finish this
                                    // sample, then idle
                                    state <= IDLE;
                                    sel   <= '0;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_playback_sched.sv
// Randomised bench for rom_playback_sched with a sample-level
// reference model and hand-timed scenario checks.
module tb_rom_playback_sched;

    localparam int DIV = 11;
    localparam int LENS [4] = '{132, 121, 88, 55};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [3:0] en = 4'h0;
    logic [7:0] rd0 = 8'h0, rd1 = 8'h0, rd2 = 8'h0, rd3 = 8'h0;
    logic [7:0] addr;
    logic [1:0] sel;
    logic [7:0] sample;
    logic       sample_valid, seg_done, busy;

    logic [7:0] rom [4][256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rom_playback_sched dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .en           (en),
        .rom0_data    (rd0),
        .rom1_data    (rd1),
        .rom2_data    (rd2),
        .rom3_data    (rd3),
        .addr         (addr),
        .sel          (sel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .seg_done     (seg_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs, one-cycle read latency
    always @(posedge clk) begin
        rd0 <= rom[0][addr];
        rd1 <= rom[1][addr];
        rd2 <= rom[2][addr];
        rd3 <= rom[3][addr];
    end

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cyc %0d: got %0d want %0d",
                         n, cyc, got, want);
        end
    endtask

    function automatic int nxt_rom(input logic [3:0] e, input int s);
        for (int i = 1; i <= 4; i++) begin
            if (e[(s + i) % 4]) return (s + i) % 4;
        end
        return -1;
    endfunction

    // Reference model: which ROM, how many samples into it,
    // cycles since the previous sample.
    bit       m_busy = 0;
    int       m_rom = 0;
    int       m_idx = 0;
    int       m_wait = 0;
    bit       e_sv = 0, e_sd = 0, e_busy = 0;
    int       e_sample = 0, e_addr = 0, e_sel = 0;

    always @(posedge clk) begin : model
        bit b, sv, sd;
        int r, x, w, smp, s;
        b = m_busy; r = m_rom; x = m_idx; w = m_wait;
        sv = 0; sd = 0; smp = e_sample; s = e_sel;
        if (reset || (b && !run)) begin
            b = 0; r = 0; x = 0; w = 0; smp = 0; s = 0;
        end else if (!b) begin
            smp = 0; s = 0; x = 0; w = 0; r = 0;
            if (run && en != 0) begin
                b = 1; r = nxt_rom(en, 3); s = r;
            end
        end else begin
            w = w + 1;
            if (w == DIV) begin
                w = 0; sv = 1;
                smp = rom[r][x];
                if (x == LENS[r] - 1) begin
                    sd = 1; x = 0;
                    r = nxt_rom(en, r);
                    if (r < 0) begin
                        b = 0; r = 0;
                    end
                    s = r;
                end else begin
                    x = x + 1;
                end
            end
        end
        m_busy   <= b;
        m_rom    <= r;
        m_idx    <= x;
        m_wait   <= w;
        e_sv     <= sv;
        e_sd     <= sd;
        e_busy   <= b;
        e_sample <= smp;
        e_sel    <= s;
        e_addr   <= b ? x : 0;
    end

    always @(negedge clk) begin
        cyc++;
        chk("sample_valid", int'(sample_valid), int'(e_sv));
        chk("seg_done", int'(seg_done), int'(e_sd));
        chk("busy", int'(busy), int'(e_busy));
        chk("sample", int'(sample), e_sample);
        chk("addr", int'(addr), e_addr);
        chk("sel", int'(sel), e_sel);
    end

    task automatic wait_sv(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < bound);
        if (!sample_valid) chk("wait_sample_valid_timeout", 0, 1);
    endtask

    task automatic restart(input logic [3:0] e);
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        reset = 1'b0; en = e; run = 1'b1;
        @(negedge clk);
    endtask

    initial begin : drive
        int n, cnt, t0, gaps_bad;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 256; a++)
                rom[k][a] = 8'($urandom);

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_sample", int'(sample), 0);

        // Single ROM loops
        reset = 1'b0; run = 1'b1; en = 4'b0001;
        @(negedge clk);
        chk("busy_rise", int'(busy), 1);
        t0 = cyc;
        wait_sv(50, n);
        chk("first_latency", n, 11);
        chk("first_sample", int'(sample), int'(rom[0][0]));
        cnt = 1;
        while (!seg_done && cnt < 300) begin
            wait_sv(2 * DIV, n);
            cnt++;
        end
        chk("seg0_len", cnt, 132);
        chk("seg0_cycles", cyc - t0, 1452);
        chk("loop_sel", int'(sel), 0);
        chk("loop_addr", int'(addr), 0);
        wait_sv(2 * DIV, n);
        chk("loop_gap", n, 11);
        chk("loop_sample", int'(sample), int'(rom[0][0]));

        // Full rotation
        restart(4'b1111);
        gaps_bad = 0;
        for (int s = 0; s < 5; s++) begin
            cnt = 0;
            do begin
                wait_sv(2 * DIV, n);
                if (n != DIV) gaps_bad++;
                cnt++;
            end while (!seg_done && cnt < 300);
            chk("rot_len", cnt, LENS[s % 4]);
            chk("rot_sel", int'(sel), (s + 1) % 4);
        end
        chk("rot_gaps", gaps_bad, 0);

        // en change mid-segment is deferred
        restart(4'b0101);
        repeat (20) wait_sv(2 * DIV, n);
        en = 4'b0010;
        cnt = 20;
        while (!seg_done && cnt < 300) begin
            wait_sv(2 * DIV, n);
            cnt++;
        end
        chk("defer_len", cnt, 132);
        chk("defer_sel", int'(sel), 1);

        // run dropped mid ROM 2
        restart(4'b1111);
        cnt = 0;
        while (cnt < 2) begin
            wait_sv(2 * DIV, n);
            if (seg_done || n >= 2 * DIV) cnt++;
        end
        chk("abort_sel_pre", int'(sel), 2);
        repeat (50) wait_sv(2 * DIV, n);
        run = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_addr", int'(addr), 0);
        chk("abort_sample", int'(sample), 0);
        chk("abort_seg_done", int'(seg_done), 0);
        en = 4'b0110; run = 1'b1;
        @(negedge clk);
        chk("rerun_busy", int'(busy), 1);
        chk("rerun_sel", int'(sel), 1);
        chk("rerun_addr", int'(addr), 0);

        // en cleared mid-segment: finish, then idle
        repeat (5) wait_sv(2 * DIV, n);
        en = 4'b0000;
        cnt = 5;
        while (!seg_done && cnt < 300) begin
            wait_sv(2 * DIV, n);
            cnt++;
        end
        chk("drain_len", cnt, 121);
        chk("drain_busy", int'(busy), 0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (sample_valid || busy) cnt++;
        end
        chk("drain_idle", cnt, 0);

        // run with en=0 from reset stays idle
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        run = 1'b1; en = 4'b0000;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (sample_valid || busy || seg_done) cnt++;
        end
        chk("en0_idle", cnt, 0);

        // reset on a tick edge
        en = 4'b1000;
        @(negedge clk);
        wait_sv(2 * DIV, n);
        repeat (DIV - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tick_sv", int'(sample_valid), 0);
        chk("rst_tick_busy", int'(busy), 0);
        chk("rst_tick_sample", int'(sample), 0);
        chk("rst_tick_addr", int'(addr), 0);
        reset = 1'b0;

        // Random traffic
        run = 1'b1; en = 4'($urandom);
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0) en = 4'($urandom);
            if (!run) run = ($urandom_range(0, 3) == 0);
            else run = ($urandom_range(0, 699) != 0);
        end
        reset = 1'b0; run = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rom_playback_sched.md
# rom_playback_sched

Sequencer for the four 8-bit waveform ROMs feeding the audio/DAC output path. Generates a shared ROM address, selects one ROM at a time, and plays enabled segments in round-robin order at a divided sample rate. Replaces ad-hoc switch/counter sequencing in front of the output stage with one scheduler that owns ROM access.

## Interface
Parameters:
- DIV, 11: clock cycles per sample tick, ≥ 2.
- LEN0, 132: samples in ROM 0 segment, 1..256.
- LEN1, 121: samples in ROM 1 segment.
- LEN2, 88: samples in ROM 2 segment.
- LEN3, 55: samples in ROM 3 segment.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = play, 0 = abort and return to idle.
- en  in  4  per-ROM enable (from sw1..sw4); bit k enables ROM k.
- rom0_data … rom3_data  in  8 each  synchronous ROM outputs, 1-cycle read latency from addr.
- addr  out  8  shared ROM address.
- sel  out  2  index of the ROM being played.
- sample  out  8  current output sample.
- sample_valid  out  1  one-cycle pulse per new sample.
- seg_done  out  1  one-cycle pulse on last sample of a segment.
- busy  out  1  high in PLAY.

## Operation
- States: IDLE, PLAY.
- Reset value of every output: 0; state IDLE; prescaler 0.
- IDLE: addr=0, sel=0, sample=0, no pulses. If run=1 and en≠0: go to PLAY, sel ← lowest set bit of en, addr ← 0, prescaler ← 0.
- IDLE with run=1, en=0: stay IDLE.
- PLAY: prescaler counts 0..DIV-1, wraps; tick = prescaler==DIV-1.
- On tick: sample ← rom_data[sel], sample_valid=1.
  - If addr == LEN[sel]-1: seg_done=1, addr ← 0, prescaler continues wrapping; sel ← first set bit of en searching sel+1, sel+2, sel+3, sel (mod 4). If en==0 at this edge: go IDLE (sample cleared, busy drops).
  - Else addr ← addr+1.
- en is sampled only at segment boundaries; en changes mid-segment do not truncate the current segment.
- Single enabled ROM: that segment loops continuously.
- run=0 in PLAY: next edge → IDLE, all outputs to reset values; any in-flight segment abandoned, no seg_done.
- reset overrides run and everything else in the same edge.
- Addresses are 8-bit unsigned; LEN_k-1 comparison exact, no wrap beyond LEN_k-1.

## Timing
- busy rises on the edge after run=1 ∧ en≠0 is sampled (edge E0).
- First sample_valid visible after edge E0+DIV; subsequent pulses every DIV cycles, no gaps across segment boundaries.
- addr changes on tick edges only; ROM has ≥ DIV-1 ≥ 1 cycles to settle before next capture.
- Segment k duration: LEN_k × DIV cycles; seg_done coincident with its last sample_valid.
- sample holds between ticks; sel changes on the same edge as seg_done.
- Return to IDLE: 1 cycle after run=0 or reset.

## Structure
- Shared package rom_pkg: ROM count (4), sample width (8), default length constants LEN0..LEN3, DIV default, state encoding (IDLE, PLAY).
- One sub-module: sample_tick_gen (prescaler, clear input, tick output, parameter DIV).
- Round-robin next-index search and length mux stay in the top.

## Test plan
- Reset, then run=1, en=4'b0001, DIV=11 → busy after 1 cycle; first sample_valid 11 cycles later with sample = rom0[0]; seg_done after 132 samples (1452 cycles); ROM 0 loops with addr back to 0.
- en=4'b1111 → segments play sel 0,1,2,3,0 with 132/121/88/55 samples; seg_done at each boundary; no missed or duplicate tick.
- en=4'b0101, then change to 4'b0010 mid ROM 0 → ROM 0 completes all 132 samples, next sel=1.
- run dropped at sample 50 of ROM 2 → next cycle: busy=0, addr=0, sample=0, no seg_done; re-raising run restarts at lowest enabled ROM, addr 0.
- en cleared mid-segment → current segment finishes, seg_done pulses, then IDLE; run=1 with en=0 from reset → stays IDLE, no pulses.
- reset asserted during PLAY concurrent with tick → all outputs 0 next cycle, no sample_valid.
